// File: rtl/aes_key_pkg.sv
// Shared definitions for the AES-128 key-schedule blocks: sizes, FSM states,
// composite-field S-box, round constants and InvMixColumns helpers.
package aes_key_pkg;

    localparam int unsigned AES128_ROUNDS = 10;
    localparam int unsigned AES_KEY_W     = 128;

    typedef enum logic [0:0] {IDLE, EMIT} key_state_t;

    // GF(2^2) multiply (tower basis)
    function automatic logic [1:0] gf2_mul(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] k;
        k[1] = (a[1] & b[1]) ^ (a[0] & b[1]) ^ (a[1] & b[0]);
        k[0] = (a[1] & b[1]) ^ (a[0] & b[0]);
        return k;
    endfunction

    // GF(2^2) multiply by constant phi = {10}
    function automatic logic [1:0] gf2_mul_phi(input logic [1:0] q);
        return {q[1] ^ q[0], q[1]};
    endfunction

    // GF(2^4) multiply built from GF(2^2) sub-multipliers
    function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] hh, ll, hi, lo;
        hh = gf2_mul(a[3:2], b[3:2]);
        ll = gf2_mul(a[1:0], b[1:0]);
        hi = gf2_mul(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]) ^ ll;
        lo = gf2_mul_phi(hh) ^ ll;
        return {hi, lo};
    endfunction

    function automatic logic [3:0] gf4_sq(input logic [3:0] q);
        return {q[3], q[3] ^ q[2], q[2] ^ q[1], q[3] ^ q[1] ^ q[0]};
    endfunction

    // GF(2^4) multiply by constant lambda = {1100}
    function automatic logic [3:0] gf4_mul_lambda(input logic [3:0] q);
        return {q[2] ^ q[0], q[3] ^ q[2] ^ q[1] ^ q[0], q[3], q[2]};
    endfunction

    function automatic logic [3:0] gf4_inv(input logic [3:0] a);
        logic [3:0] q;
        q[3] = a[3] ^ (a[3] & a[2] & a[1]) ^ (a[3] & a[0]) ^ a[2];
        q[2] = (a[3] & a[2] & a[1]) ^ (a[3] & a[2] & a[0]) ^ (a[3] & a[0]) ^ a[2]
             ^ (a[2] & a[1]);
        q[1] = a[3] ^ (a[3] & a[2] & a[1]) ^ (a[3] & a[1] & a[0]) ^ a[2]
             ^ (a[2] & a[0]) ^ a[1];
        q[0] = (a[3] & a[2] & a[1]) ^ (a[3] & a[2] & a[0]) ^ (a[3] & a[1])
             ^ (a[3] & a[1] & a[0]) ^ (a[3] & a[0]) ^ a[2] ^ (a[2] & a[1])
             ^ (a[2] & a[1] & a[0]) ^ a[1] ^ a[0];
        return q;
    endfunction

    // Isomorphism GF(2^8) -> GF((2^4)^2)
    function automatic logic [7:0] iso_map(input logic [7:0] a);
        logic [7:0] q;
        q[7] = a[7] ^ a[5];
        q[6] = a[7] ^ a[6] ^ a[4] ^ a[3] ^ a[2] ^ a[1];
        q[5] = a[7] ^ a[5] ^ a[3] ^ a[2];
        q[4] = a[7] ^ a[5] ^ a[3] ^ a[2] ^ a[1];
        q[3] = a[7] ^ a[6] ^ a[2] ^ a[1];
        q[2] = a[7] ^ a[4] ^ a[3] ^ a[2] ^ a[1];
        q[1] = a[6] ^ a[4] ^ a[1];
        q[0] = a[6] ^ a[1] ^ a[0];
        return q;
    endfunction

    // Isomorphism GF((2^4)^2) -> GF(2^8)
    function automatic logic [7:0] iso_inv(input logic [7:0] a);
        logic [7:0] q;
        q[7] = a[7] ^ a[6] ^ a[5] ^ a[1];
        q[6] = a[6] ^ a[2];
        q[5] = a[6] ^ a[5] ^ a[1];
        q[4] = a[6] ^ a[5] ^ a[4] ^ a[2] ^ a[1];
        q[3] = a[5] ^ a[4] ^ a[3] ^ a[2] ^ a[1];
        q[2] = a[7] ^ a[4] ^ a[3] ^ a[2] ^ a[1];
        q[1] = a[5] ^ a[4];
        q[0] = a[6] ^ a[5] ^ a[4] ^ a[2] ^ a[0];
        return q;
    endfunction

    // Forward AES S-box: composite-field inverse followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] m, y, z, s;
        logic [3:0] ah, al, d, di;
        m  = iso_map(x);
        ah = m[7:4];
        al = m[3:0];
        d  = gf4_mul_lambda(gf4_sq(ah)) ^ gf4_mul(ah ^ al, al);
        di = gf4_inv(d);
        y  = {gf4_mul(ah, di), gf4_mul(ah ^ al, di)};
        z  = iso_inv(y);
        for (int unsigned i = 0; i < 8; i++) begin
            s[i] = z[i] ^ z[(i + 4) % 8] ^ z[(i + 5) % 8] ^ z[(i + 6) % 8] ^ z[(i + 7) % 8];
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // InvMixColumns of one column, byte 0 in [31:24]
    function automatic logic [31:0] inv_mixcol_word(input logic [31:0] w);
        logic [7:0] b  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [31:0] o;
        for (int unsigned i = 0; i < 4; i++) begin
            b[i]  = w[31 - 8*i -: 8];
            x2[i] = xtime(b[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ b[i];
            mb[i] = x8[i] ^ x2[i] ^ b[i];
            md[i] = x8[i] ^ x4[i] ^ b[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        for (int unsigned i = 0; i < 4; i++) begin
            o[31 - 8*i -: 8] = me[i] ^ mb[(i + 1) % 4] ^ md[(i + 2) % 4] ^ m9[(i + 3) % 4];
        end
        return o;
    endfunction

    function automatic logic [AES_KEY_W-1:0] inv_mixcol_key(input logic [AES_KEY_W-1:0] k);
        return {inv_mixcol_word(k[127:96]), inv_mixcol_word(k[95:64]),
                inv_mixcol_word(k[63:32]),  inv_mixcol_word(k[31:0])};
    endfunction

endpackage

// File: rtl/inv_round_key_gen_128.sv
// One reverse step of the AES-128 key schedule: round-r key -> round-(r-1) key.
module inv_round_key_gen_128
    import aes_key_pkg::*;
(
    input  logic [AES_KEY_W-1:0] key_in,
    input  logic [3:0]           rnd,
    output logic [AES_KEY_W-1:0] key_out
);

    logic [31:0] k0, k1, k2, k3;
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] sub_rot;

    // Undo the word chaining, then recover word 0 through RotWord/SubWord/rcon
    always_comb begin
        k0 = key_in[127:96];
        k1 = key_in[95:64];
        k2 = key_in[63:32];
        k3 = key_in[31:0];
        p3 = k3 ^ k2;
        p2 = k2 ^ k1;
        p1 = k1 ^ k0;
        sub_rot = {sbox(p3[23:16]), sbox(p3[15:8]), sbox(p3[7:0]), sbox(p3[31:24])};
        p0 = k0 ^ sub_rot ^ {rcon(rnd), 24'h0};
        key_out = {p0, p1, p2, p3};
    end

endmodule

// File: rtl/aes_inv_keyexp_128.sv
// Reverse AES-128 key schedule: emits round keys 10 down to 0 over a
// valid/ready handshake, starting from the round-10 key.
// Optional: AES_INV_KEYEXP_MIXCOL_EN maps rounds 9..1 through InvMixColumns
// (equivalent-inverse-cipher keys); the stored schedule stays raw.
module aes_inv_keyexp_128
    import aes_key_pkg::*;
#(
    parameter int unsigned ROUNDS = AES128_ROUNDS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [AES_KEY_W-1:0] last_key,
    input  logic                 skey_ready,
    output logic [AES_KEY_W-1:0] subkey,
    output logic [3:0]           round,
    output logic                 valid_skey,
    output logic                 done
);

    key_state_t           state;
    logic [AES_KEY_W-1:0] key_r;
    logic [AES_KEY_W-1:0] key_prev;

    inv_round_key_gen_128 u_step (
        .key_in  (key_r),
        .rnd     (round),
        .key_out (key_prev)
    );

    // Sequence control: load on start, step back one round per handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            key_r      <= '0;
            round      <= '0;
            valid_skey <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        key_r      <= last_key;
                        round      <= 4'(ROUNDS);
                        valid_skey <= 1'b1;
                        state      <= EMIT;
                    end
                end
                EMIT: begin
                    if (valid_skey && skey_ready) begin
                        if (round != 4'd0) begin
                            key_r <= key_prev;
                            round <= round - 4'd1;
                        end else begin
                            valid_skey <= 1'b0;
                            done       <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AES_INV_KEYEXP_MIXCOL_EN
    // Middle rounds leave as equivalent-inverse-cipher keys; ends stay raw
    always_comb begin
        subkey = key_r;
        if (round != 4'd0 && round != 4'(ROUNDS)) begin
            subkey = inv_mixcol_key(key_r);
        end
    end
`else
    // Raw schedule straight from the key register
    always_comb begin
        subkey = key_r;
    end
`endif

endmodule

// File: tb/tb_aes_inv_keyexp_128.sv
// Directed bench for aes_inv_keyexp_128 (honours AES_INV_KEYEXP_MIXCOL_EN).
module tb_aes_inv_keyexp_128;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] last_key;
    logic         skey_ready;
    logic [127:0] subkey;
    logic [3:0]   round;
    logic         valid_skey;
    logic         done;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [127:0] exp_keys [0:10];

    always #5 clk = ~clk;

    aes_inv_keyexp_128 #(.ROUNDS(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .last_key   (last_key),
        .skey_ready (skey_ready),
        .subkey     (subkey),
        .round      (round),
        .valid_skey (valid_skey),
        .done       (done)
    );

    // ---------------- reference model (plain GF(2^8) arithmetic) ----------------
    function automatic logic [7:0] m_mul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] m_sbox(input logic [7:0] x);
        logic [7:0] z, s;
        z = 8'h01;
        for (int i = 0; i < 254; i++) z = m_mul(z, x);
        s = z ^ {z[6:0], z[7]} ^ {z[5:0], z[7:6]} ^ {z[4:0], z[7:5]} ^ {z[3:0], z[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [127:0] m_next(input logic [127:0] k, input int r);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 1; i < r; i++) rc = m_mul(rc, 8'h02);
        w3 = k[31:0];
        t  = {m_sbox(w3[23:16]) ^ rc, m_sbox(w3[15:8]), m_sbox(w3[7:0]), m_sbox(w3[31:24])};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] m_invmc(input logic [127:0] k);
        logic [127:0] o;
        logic [7:0]   c [4];
        for (int col = 0; col < 4; col++) begin
            for (int j = 0; j < 4; j++) c[j] = k[127 - 32*col - 8*j -: 8];
            for (int j = 0; j < 4; j++) begin
                o[127 - 32*col - 8*j -: 8] = m_mul(c[j], 8'h0e) ^ m_mul(c[(j+1)%4], 8'h0b)
                                           ^ m_mul(c[(j+2)%4], 8'h0d) ^ m_mul(c[(j+3)%4], 8'h09);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] exp_sub(input int r);
`ifdef AES_INV_KEYEXP_MIXCOL_EN
        if (r >= 1 && r <= 9) return m_invmc(exp_keys[r]);
`endif
        return exp_keys[r];
    endfunction

    task automatic fill_fwd(input logic [127:0] k);
        exp_keys[0] = k;
        for (int r = 1; r <= 10; r++) exp_keys[r] = m_next(exp_keys[r-1], r);
    endtask

    task automatic fill_fips;
        exp_keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        exp_keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp_keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp_keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp_keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp_keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp_keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp_keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp_keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp_keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Run one full sequence from the current negedge; ends at the negedge showing done.
    task automatic run_seq(input string tag, input bit rnd_ready, input bit poke);
        int          r = 10;
        int unsigned cycles = 0;
        bit          rdy;
        bit          fin = 1'b0;
        logic [127:0] k;
        k = exp_keys[10];
        start = 1'b1; last_key = k; skey_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_latency_valid"}, 128'(valid_skey), 128'(1));
        while (!fin && cycles < 400) begin
            chk({tag, "_valid"}, 128'(valid_skey), 128'(1));
            chk({tag, "_round"}, 128'(round), 128'(r));
            chk({tag, "_subkey"}, subkey, exp_sub(r));
            chk({tag, "_done_low"}, 128'(done), 128'(0));
            rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            skey_ready = rdy;
            start = poke && (r == 6 || r == 0);
            last_key = poke ? ~k : k;
            @(negedge clk);
            cycles++;
            start = 1'b0;
            if (rdy) begin
                if (r == 0) fin = 1'b1;
                else r--;
            end
        end
        skey_ready = 1'b0;
        chk({tag, "_timeout"}, 128'(fin), 128'(1));
        if (!rnd_ready) chk({tag, "_cycles"}, 128'(cycles), 128'(11));
        chk({tag, "_done_pulse"}, 128'(done), 128'(1));
        chk({tag, "_done_valid"}, 128'(valid_skey), 128'(0));
        chk({tag, "_done_round"}, 128'(round), 128'(0));
        @(negedge clk);
        chk({tag, "_done_fall"}, 128'(done), 128'(0));
        chk({tag, "_idle_valid"}, 128'(valid_skey), 128'(0));
    endtask

    initial begin
        int unsigned waited;
        reset = 1'b1; start = 1'b0; last_key = '0; skey_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_subkey", subkey, 128'h0);
        chk("reset_round", 128'(round), 128'(0));
        chk("reset_valid", 128'(valid_skey), 128'(0));
        chk("reset_done", 128'(done), 128'(0));
        reset = 1'b0;
        @(negedge clk);

        // Scenario 1: FIPS-197 key, ready held high
        fill_fips();
        run_seq("s1", 1'b0, 1'b0);

        // Scenario 2: same key, random backpressure
        run_seq("s2", 1'b1, 1'b0);

        // Scenario 3: start pokes during EMIT ignored; restart right after done
        run_seq("s3", 1'b0, 1'b1);
        run_seq("s3b", 1'b0, 1'b0);

        // Scenario 4: reset while round 5 is on the output
        start = 1'b1; last_key = exp_keys[10]; skey_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (round !== 4'd5 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("s4_reach_r5", 128'(round), 128'(5));
        reset = 1'b1; skey_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("s4_valid", 128'(valid_skey), 128'(0));
        chk("s4_subkey", subkey, 128'h0);
        chk("s4_round", 128'(round), 128'(0));
        chk("s4_done", 128'(done), 128'(0));
        run_seq("s4_rerun", 1'b0, 1'b0);

        // Scenario 5: round trip against the forward schedule model
        for (int n = 0; n < 4; n++) begin
            fill_fwd({$urandom, $urandom, $urandom, $urandom});
            run_seq("s5", (n % 2) == 1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
